// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the PISO serializer family.
// Optional feature macro used by this block: PISO_PARITY_EN (appends a parity bit).
package piso_pkg;

  // Largest frame width the serializer is meant to be built with.
  localparam int WIDTH_MAX = 64;

  // Frame FSM states; ST_PAR is only reachable when PISO_PARITY_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } piso_state_e;

  // Counter width able to hold 0..width inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle of the PISO serializer.
// Optional feature macro affecting the attached serializer: PISO_PARITY_EN.
//
// Handshake: a frame transfers on every rising clock edge where load_valid
// and load_ready are both high. load_valid, parallel_in and msb_first must be
// held stable by the source until that edge; load_ready may change freely and
// does not depend combinationally on load_valid.
interface piso_serializer_if
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  logic             enable;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] parallel_in;
  logic             msb_first;
  logic             serial_out;
  logic             serial_valid;
  logic             busy;
  logic             frame_done;
  piso_state_e      dbg_state;

  // Source / controller side.
  modport master (
    output enable, load_valid, parallel_in, msb_first,
    input  load_ready, serial_out, serial_valid, busy, frame_done, dbg_state
  );

  // Serializer side.
  modport slave (
    input  enable, load_valid, parallel_in, msb_first,
    output load_ready, serial_out, serial_valid, busy, frame_done, dbg_state
  );

endinterface

// File: rtl/piso_serializer_frame_counter.sv
// Bit-position counter for serial framing: cleared at frame start, stepped per
// transferred bit, saturating at WIDTH. last_o flags bit position WIDTH-1.
// Not affected by PISO_PARITY_EN; the parity cycle simply does not step it.
module piso_frame_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear_i,
  input  logic                      step_i,
  output logic [cnt_w(WIDTH)-1:0]   cnt_o,
  output logic                      last_o
);

  localparam int CW = cnt_w(WIDTH);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over step; never runs past WIDTH.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (step_i && (cnt_q != CW'(WIDTH))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parametrised parallel-in/serial-out serializer with valid/ready load,
// per-frame bit order, frame_done, gap-free back-to-back frames and an
// enable input that freezes all state.
// Optional feature macro: PISO_PARITY_EN (one parity bit after the data bits,
// sense chosen by ODD_PARITY). Default build has no parity stage.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  piso_serializer_if.slave   bus
);

  localparam int CW = cnt_w(WIDTH);

  piso_state_e      state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic             order_q;
  logic [CW-1:0]    cnt;
  logic             cnt_last;
  logic             last_data;
  logic             frame_last;
  logic             load_ready;
  logic             accept;
  logic             cnt_step;
  logic             serial_bit;

`ifdef PISO_PARITY_EN
  logic parity_q;
  logic parity_d;
  assign parity_d   = (^bus.parallel_in) ^ ODD_PARITY;
  // The parity cycle closes the frame.
  assign frame_last = (state_q == ST_PAR);
`else
  logic unused_odd_parity;
  assign unused_odd_parity = ODD_PARITY;
  assign frame_last        = last_data;
`endif

  assign last_data  = (state_q == ST_SHIFT) && cnt_last;
  // reset_n keeps load_ready low while reset is asserted even if enable is high.
  assign load_ready = reset_n & bus.enable & ((state_q == ST_IDLE) | frame_last);
  assign accept     = bus.load_valid & load_ready;
  assign cnt_step   = bus.enable & (state_q == ST_SHIFT) & ~accept;

  // Shift toward whichever end feeds serial_out, zero-filling behind.
  assign shift_d = order_q ? {shift_q[WIDTH-2:0], 1'b0}
                           : {1'b0, shift_q[WIDTH-1:1]};

  piso_frame_counter #(
    .WIDTH (WIDTH)
  ) u_frame_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (accept),
    .step_i  (cnt_step),
    .cnt_o   (cnt),
    .last_o  (cnt_last)
  );

  // Frame FSM plus data/order/parity latches; nothing moves while enable is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      order_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (bus.enable) begin
      if (accept) begin
        state_q  <= ST_SHIFT;
        shift_q  <= bus.parallel_in;
        order_q  <= bus.msb_first;
`ifdef PISO_PARITY_EN
        parity_q <= parity_d;
`endif
      end else begin
        unique case (state_q)
          ST_SHIFT: begin
            shift_q <= shift_d;
            if (cnt_last) begin
`ifdef PISO_PARITY_EN
              state_q <= ST_PAR;
`else
              state_q <= ST_IDLE;
`endif
            end
          end
          ST_PAR:  state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Output bit select: data bit in SHIFT, parity in PAR, 0 when idle.
  always_comb begin
    serial_bit = 1'b0;
    case (state_q)
      ST_SHIFT: serial_bit = order_q ? shift_q[WIDTH-1] : shift_q[0];
`ifdef PISO_PARITY_EN
      ST_PAR:   serial_bit = parity_q;
`endif
      default:  serial_bit = 1'b0;
    endcase
  end

  assign bus.serial_out   = serial_bit;
  assign bus.serial_valid = bus.enable & (state_q != ST_IDLE);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.frame_done   = bus.enable & frame_last;
  assign bus.load_ready   = load_ready;
  assign bus.dbg_state    = state_q;

endmodule
